parking_gate_controller: RTL and testbench

Sequential front-end for the parking occupancy datapath. It debounces the raw entry and exit vehicle sensors and arbitrates between simultaneous requests. It drives the operands and add/subtract select of the 2-bit adder-subtractor, then registers that block's result as the lot occupancy. It also runs the entry and exit gate timers and flags full, empty and denied-entry conditions for the display/status logic.

---
 rtl/parking_gate_controller.sv | 194 +++++++++++++++++++
 tb/tb_parking_gate_controller.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_gate_controller.sv
// Parking lot gate controller: debounces the entry/exit loop sensors,
// arbitrates requests (exit first), steers the external 2-bit
// adder-subtractor, registers the resulting occupancy and times the
// entry/exit barriers.

// Per-sensor front end: 2-flop synchronizer, run-length debounce, and a
// rising-edge strobe of the debounced level.
module parking_gate_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic raw_i,
    output logic rise_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lvl_q, lvl_d;
    logic          lvl_prev_q;

    // Count consecutive samples that disagree with the debounced level;
    // flip the level on the last one, any agreeing sample restarts the run.
    always_comb begin
        cnt_d = '0;
        lvl_d = lvl_q;
        if (sync_q[1] != lvl_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                lvl_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Synchronizer, debounce state and previous level for edge detection.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q     <= '0;
            cnt_q      <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], raw_i};
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
        end
    end

    assign rise_o = lvl_q & ~lvl_prev_q;

endmodule

module parking_gate_controller #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int GATE_CYCLES     = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       entry_sensor_i,
    input  logic       exit_sensor_i,
    input  logic [2:0] sum_in_i,
    output logic       op_sel_o,
    output logic [1:0] op_a_o,
    output logic [1:0] op_b_o,
    output logic [1:0] count_o,
    output logic       full_o,
    output logic       empty_o,
    output logic       entry_gate_o,
    output logic       exit_gate_o,
    output logic       denied_o
);
    localparam int NUM_SENSORS = 2;
    localparam int ENT = 0;
    localparam int EXT = 1;
    localparam int TW  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;

    typedef enum logic [2:0] {
        IDLE,
        COMMIT_ENTRY,
        COMMIT_EXIT,
        GATE_ENTRY,
        GATE_EXIT
    } state_t;

    state_t                 state_q, state_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [1:0]             count_q, count_d;
    logic                   op_sel_q, op_sel_d;
    logic                   denied_q, denied_d;
    logic [NUM_SENSORS-1:0] raw, rise;
    logic [NUM_SENSORS-1:0] pend_q, pend_d;
    logic [NUM_SENSORS-1:0] clr;
    logic                   unused_carry;

    // The adder carry is never needed: the IDLE guards prevent wrap.
    assign unused_carry = sum_in_i[2];

    assign raw[ENT] = entry_sensor_i;
    assign raw[EXT] = exit_sensor_i;

    for (genvar s = 0; s < NUM_SENSORS; s++) begin : g_sensor
        parking_gate_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .raw_i (raw[s]),
            .rise_o(rise[s])
        );
    end

    // Arbitration, commit and gate timing; exit outranks entry and only one
    // request is consumed per IDLE cycle.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        count_d  = count_q;
        op_sel_d = op_sel_q;
        denied_d = 1'b0;
        clr      = '0;
        case (state_q)
            IDLE: begin
                if (pend_q[EXT] && (count_q != 2'd0)) begin
                    clr[EXT] = 1'b1;
                    op_sel_d = 1'b1;
                    state_d  = COMMIT_EXIT;
                end else if (pend_q[EXT]) begin
                    clr[EXT] = 1'b1;
                end else if (pend_q[ENT] && (count_q == 2'd3)) begin
                    clr[ENT] = 1'b1;
                    denied_d = 1'b1;
                end else if (pend_q[ENT]) begin
                    clr[ENT] = 1'b1;
                    op_sel_d = 1'b0;
                    state_d  = COMMIT_ENTRY;
                end
            end
            COMMIT_ENTRY: begin
                count_d = sum_in_i[1:0];
                timer_d = TW'(GATE_CYCLES - 1);
                state_d = GATE_ENTRY;
            end
            COMMIT_EXIT: begin
                count_d = sum_in_i[1:0];
                timer_d = TW'(GATE_CYCLES - 1);
                state_d = GATE_EXIT;
            end
            GATE_ENTRY, GATE_EXIT: begin
                if (timer_q == '0) begin
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        // A request being served or denied wins over a new edge; edges on
        // an already pending flag are absorbed.
        pend_d = (pend_q | rise) & ~clr;
    end

    // Controller state, occupancy and registered outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            count_q  <= '0;
            op_sel_q <= 1'b0;
            denied_q <= 1'b0;
            pend_q   <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            count_q  <= count_d;
            op_sel_q <= op_sel_d;
            denied_q <= denied_d;
            pend_q   <= pend_d;
        end
    end

    assign op_sel_o     = op_sel_q;
    assign op_a_o       = count_q;
    assign op_b_o       = 2'b01;
    assign count_o      = count_q;
    assign full_o       = (count_q == 2'd3);
    assign empty_o      = (count_q == 2'd0);
    assign entry_gate_o = (state_q == GATE_ENTRY);
    assign exit_gate_o  = (state_q == GATE_EXIT);
    assign denied_o     = denied_q;

endmodule

// File: tb/tb_parking_gate_controller.sv
// Bench for parking_gate_controller: reset checks, a cycle-exact entry
// trace, a table of sensor pulses with windowed expectations, reset during
// a gate, and a randomized run against a timestamp-based reference model.
module tb_parking_gate_controller;
    localparam int D    = 4;
    localparam int G    = 8;
    localparam int NRND = 3000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ent = 1'b0;
    logic       ext = 1'b0;
    logic [2:0] sum_in;
    logic       op_sel, full, empty, eg, xg, denied;
    logic [1:0] op_a, op_b, count;

    int checks = 0;
    int errors = 0;

    parking_gate_controller #(.DEBOUNCE_CYCLES(D), .GATE_CYCLES(G)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .entry_sensor_i(ent),
        .exit_sensor_i (ext),
        .sum_in_i      (sum_in),
        .op_sel_o      (op_sel),
        .op_a_o        (op_a),
        .op_b_o        (op_b),
        .count_o       (count),
        .full_o        (full),
        .empty_o       (empty),
        .entry_gate_o  (eg),
        .exit_gate_o   (xg),
        .denied_o      (denied)
    );

    always #5 clk = ~clk;

    // External 2-bit adder-subtractor
    assign sum_in = op_sel ? ({1'b0, op_a} - {1'b0, op_b}) : ({1'b0, op_a} + {1'b0, op_b});

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
    endtask

    // ---------------- table-driven pulses ----------------
    typedef struct {
        string nm;
        bit    e;
        bit    x;
        int    hold;
        int    cnt;
        bit    full;
        bit    empty;
        int    egc;
        int    xgc;
        int    dnc;
    } vec_t;

    vec_t tbl[12];

    task automatic apply_row(input vec_t r);
        int egc = 0, xgc = 0, dnc = 0;
        ent = r.e;
        ext = r.x;
        for (int i = 0; i < r.hold; i++) begin
            tick();
            egc += int'(eg); xgc += int'(xg); dnc += int'(denied);
        end
        ent = 1'b0;
        ext = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            egc += int'(eg); xgc += int'(xg); dnc += int'(denied);
        end
        chk({r.nm, " count"}, count, r.cnt);
        chk({r.nm, " full/empty"}, {full, empty}, {r.full, r.empty});
        chk({r.nm, " entry_gate cycles"}, egc, r.egc);
        chk({r.nm, " exit_gate cycles"}, xgc, r.xgc);
        chk({r.nm, " denied pulses"}, dnc, r.dnc);
    endtask

    // ---------------- reference model ----------------
    // Sensors: debounced level flips once the last D synchronized samples
    // (raw delayed two edges) all disagree with it. Service is tracked by
    // timestamps: accept at edge n -> count changes and gate opens at n+1,
    // gate held through n+G, next decision at n+G+2.
    bit raw_h[2][NRND];
    bit lvl_h[2][NRND];
    bit m_pend[2];
    int m_count, m_delta, commit_at, idle_from;
    int ge_from, ge_to, gx_from, gx_to;
    bit m_opsel, m_den;
    int mn;

    function automatic bit hr(input int s, input int i);
        return (i < 0) ? 1'b0 : raw_h[s][i];
    endfunction

    function automatic bit hl(input int s, input int i);
        return (i < 0) ? 1'b0 : lvl_h[s][i];
    endfunction

    task automatic model_reset();
        m_pend    = '{1'b0, 1'b0};
        m_count   = 0;
        m_delta   = 0;
        commit_at = -1;
        idle_from = 0;
        ge_from   = 1; ge_to = 0;
        gx_from   = 1; gx_to = 0;
        m_opsel   = 1'b0;
        m_den     = 1'b0;
        mn        = 0;
    endtask

    task automatic model_step(input bit re, input bit rx);
        bit clr[2];
        int n = mn;
        clr = '{1'b0, 1'b0};
        raw_h[0][n] = re;
        raw_h[1][n] = rx;
        if (n == commit_at) m_count += m_delta;
        m_den = 1'b0;
        if (n >= idle_from) begin
            if (m_pend[1] && m_count != 0) begin
                clr[1] = 1'b1; m_opsel = 1'b1; m_delta = -1; commit_at = n + 1;
                gx_from = n + 1; gx_to = n + G; idle_from = n + G + 2;
            end else if (m_pend[1]) begin
                clr[1] = 1'b1;
            end else if (m_pend[0] && m_count == 3) begin
                clr[0] = 1'b1; m_den = 1'b1;
            end else if (m_pend[0]) begin
                clr[0] = 1'b1; m_opsel = 1'b0; m_delta = 1; commit_at = n + 1;
                ge_from = n + 1; ge_to = n + G; idle_from = n + G + 2;
            end
        end
        for (int s = 0; s < 2; s++) begin
            bit cur, all_diff;
            bit rise = hl(s, n - 1) && !hl(s, n - 2);
            m_pend[s] = clr[s] ? 1'b0 : (m_pend[s] | rise);
            cur = hl(s, n - 1);
            all_diff = 1'b1;
            for (int k = 0; k < D; k++)
                if (hr(s, n - 2 - k) == cur) all_diff = 1'b0;
            lvl_h[s][n] = all_diff ? !cur : cur;
        end
        mn++;
    endtask

    initial begin
        tbl[0]  = '{"entry1",     1, 0, 10, 1, 0, 0, 8, 0, 0};
        tbl[1]  = '{"entry2",     1, 0, 10, 2, 0, 0, 8, 0, 0};
        tbl[2]  = '{"entry3",     1, 0, 10, 3, 1, 0, 8, 0, 0};
        tbl[3]  = '{"entry_full", 1, 0, 10, 3, 1, 0, 0, 0, 1};
        tbl[4]  = '{"exit1",      0, 1, 10, 2, 0, 0, 0, 8, 0};
        tbl[5]  = '{"both",       1, 1, 10, 2, 0, 0, 8, 8, 0};
        tbl[6]  = '{"glitch3",    1, 0,  3, 2, 0, 0, 0, 0, 0};
        tbl[7]  = '{"pulse4",     1, 0,  4, 3, 1, 0, 8, 0, 0};
        tbl[8]  = '{"exit2",      0, 1, 10, 2, 0, 0, 0, 8, 0};
        tbl[9]  = '{"exit3",      0, 1, 10, 1, 0, 0, 0, 8, 0};
        tbl[10] = '{"exit4",      0, 1, 10, 0, 0, 1, 0, 8, 0};
        tbl[11] = '{"exit_empty", 0, 1, 10, 0, 0, 1, 0, 0, 0};

        // Reset state, checked before any clock edge
        #1 rst = 1'b1;
        #1;
        chk("reset count", count, 0);
        chk("reset full/empty", {full, empty}, 2'b01);
        chk("reset gates/denied", {eg, xg, denied}, 3'b000);
        chk("reset op_sel", op_sel, 0);
        chk("reset op_b", op_b, 1);

        // Cycle-exact first entry: raw high before edge 0
        #1 rst = 1'b0;
        ent = 1'b1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (k == 9) ent = 1'b0;
            chk($sformatf("trace entry_gate e%0d", k), eg, (k >= 8 && k <= 15) ? 1 : 0);
            chk($sformatf("trace count e%0d", k), count, (k >= 8) ? 1 : 0);
            chk($sformatf("trace op_sel e%0d", k), op_sel, 0);
            if (k == 7 || k == 8)
                chk($sformatf("trace empty e%0d", k), empty, (k == 7) ? 1 : 0);
        end

        // Table of pulses from an empty lot
        tick();
        do_reset();
        for (int i = 0; i < 12; i++) apply_row(tbl[i]);

        // Reset in the middle of an entry gate at count 2
        tick();
        do_reset();
        apply_row(tbl[0]);
        ent = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ent = 1'b0;
        chk("midgate entry_gate", eg, 1);
        chk("midgate count", count, 2);
        #2 rst = 1'b1;
        #1;
        chk("async rst gates", {eg, xg}, 2'b00);
        chk("async rst count", count, 0);
        chk("async rst empty", empty, 1);
        #2 rst = 1'b0;
        tick();
        apply_row(tbl[0]);

        // Randomized run against the reference model
        tick();
        ent = 1'b0;
        ext = 1'b0;
        do_reset();
        model_reset();
        begin
            int  hold[2];
            bit  lv[2];
            hold = '{0, 0};
            lv   = '{1'b0, 1'b0};
            for (int i = 0; i < NRND; i++) begin
                for (int s = 0; s < 2; s++) begin
                    if (hold[s] == 0) begin
                        lv[s]   = ($urandom_range(0, 99) < ((s == 0) ? 60 : 40));
                        hold[s] = $urandom_range(1, 18);
                    end
                    hold[s]--;
                end
                ent = lv[0];
                ext = lv[1];
                tick();
                model_step(lv[0], lv[1]);
                chk($sformatf("random cycle %0d {cnt,full,empty,eg,xg,den,sel,a,b}", i),
                    {count, full, empty, eg, xg, denied, op_sel, op_a, op_b},
                    {m_count[1:0], m_count == 3, m_count == 0,
                     (mn - 1 >= ge_from) && (mn - 1 <= ge_to),
                     (mn - 1 >= gx_from) && (mn - 1 <= gx_to),
                     m_den, m_opsel, m_count[1:0], 2'b01});
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
